// File: rtl/mini_pic.sv
// mini_pic: four-source interrupt controller that presents one vector at a time and waits for a host ack.
// Optional overrun detection is built when MINI_PIC_OVERRUN_EN is defined; otherwise the overrun port is tied to zero.
module mini_pic (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] irq_in,
    input  logic [3:0] mask,
    input  logic       ack,
    input  logic [3:0] overrun_clr,
    output logic       irq,
    output logic [1:0] vector,
    output logic [3:0] pending,
    output logic [3:0] overrun
);

    // state  | meaning
    // IDLE   | no vector presented, irq low; looking for an enabled pending source
    // ACTIVE | vector presented on irq, held until the host acks it
    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [1:0] vector_q;
    logic [1:0] vector_d;
    logic [3:0] pending_q;
    logic [3:0] clr_vec;
    logic [3:0] req;

    assign req = pending_q & mask;

    always_comb begin
        state_d  = state_q;
        vector_d = vector_q;
        clr_vec  = 4'b0000;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = ACTIVE;
                    if (req[0])      vector_d = 2'd0;
                    else if (req[1]) vector_d = 2'd1;
                    else if (req[2]) vector_d = 2'd2;
                    else             vector_d = 2'd3;
                end
            end
            ACTIVE: begin
                if (ack) begin
                    clr_vec = 4'b0001 << vector_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            vector_q  <= 2'd0;
            pending_q <= 4'b0000;
        end else begin
            state_q   <= state_d;
            vector_q  <= vector_d;
            // A new event on the source being acked wins over the clear.
            pending_q <= (pending_q & ~clr_vec) | irq_in;
        end
    end

    assign irq     = (state_q == ACTIVE);
    assign vector  = vector_q;
    assign pending = pending_q;

`ifdef MINI_PIC_OVERRUN_EN
    logic [3:0] overrun_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overrun_q <= 4'b0000;
        end else begin
            overrun_q <= (overrun_q & ~overrun_clr) | (irq_in & pending_q & ~clr_vec);
        end
    end

    assign overrun = overrun_q;
`else
    logic unused_overrun_clr;
    assign unused_overrun_clr = ^overrun_clr;
    assign overrun = 4'b0000;
`endif

endmodule

// File: tb/tb_mini_pic.sv
// tb_mini_pic: directed scenarios plus random traffic against a behavioural model;
// expected outputs are queued per cycle and a separate monitor compares them.
module tb_mini_pic;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] irq_in;
    logic [3:0] mask;
    logic       ack;
    logic [3:0] overrun_clr;
    logic       irq;
    logic [1:0] vector;
    logic [3:0] pending;
    logic [3:0] overrun;

    always #5 clk = ~clk;

    mini_pic dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .irq_in      (irq_in),
        .mask        (mask),
        .ack         (ack),
        .overrun_clr (overrun_clr),
        .irq         (irq),
        .vector      (vector),
        .pending     (pending),
        .overrun     (overrun)
    );

    typedef struct packed {
        logic [3:0] pend;
        logic [3:0] ov;
        logic       irq;
        logic [1:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    // Reference model state
    bit [3:0] m_pend;
    bit [3:0] m_ov;
    bit       m_busy;
    int       m_vec;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    endtask

    // Model: advance one clock edge using the inputs seen during the ending cycle.
    initial begin
        m_pend = 0; m_ov = 0; m_busy = 0; m_vec = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_pend = 0; m_ov = 0; m_busy = 0; m_vec = 0;
            end else begin
                int       clr;
                bit [3:0] np;
                bit [3:0] nov;
                clr = (m_busy && ack) ? m_vec : -1;
                for (int i = 0; i < 4; i++) begin
                    np[i]  = irq_in[i] || (m_pend[i] && i != clr);
                    nov[i] = m_ov[i];
`ifdef MINI_PIC_OVERRUN_EN
                    if (irq_in[i] && m_pend[i] && i != clr) nov[i] = 1'b1;
                    else if (overrun_clr[i])                nov[i] = 1'b0;
`endif
                end
                if (m_busy) begin
                    if (ack) m_busy = 0;
                end else begin
                    for (int i = 3; i >= 0; i--)
                        if (m_pend[i] && mask[i]) begin
                            m_busy = 1;
                            m_vec  = i;
                        end
                end
                m_pend = np;
                m_ov   = nov;
            end
            exp_q.push_back('{pend: m_pend, ov: m_ov, irq: m_busy, vec: 2'(m_vec)});
        end
    end

    // Monitor: compare DUT outputs mid-cycle against the queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL queue: no expected entry at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pending", int'(pending), int'(e.pend));
                chk("overrun", int'(overrun), int'(e.ov));
                chk("irq", int'(irq), int'(e.irq));
                if (e.irq) chk("vector", int'(vector), int'(e.vec));
            end
        end
    end

    task automatic drive(input logic [3:0] i_irq, input logic [3:0] i_mask,
                         input logic i_ack, input logic [3:0] i_clr, input logic i_rst_n);
        irq_in      = i_irq;
        mask        = i_mask;
        ack         = i_ack;
        overrun_clr = i_clr;
        rst_n       = i_rst_n;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic [3:0] i_mask);
        for (int k = 0; k < n; k++) drive(4'h0, i_mask, 1'b0, 4'h0, 1'b1);
    endtask

    initial begin
        drive(4'h0, 4'hF, 1'b0, 4'h0, 1'b0);
        drive(4'hF, 4'hF, 1'b1, 4'h0, 1'b0);
        idle(8, 4'hF);

        // Single source: latency and vector 2
        drive(4'b0100, 4'hF, 1'b0, 4'h0, 1'b1);
        idle(4, 4'hF);
        drive(4'h0, 4'hF, 1'b1, 4'h0, 1'b1);
        idle(3, 4'hF);

        // Two sources in one cycle, served in priority order
        drive(4'b1010, 4'hF, 1'b0, 4'h0, 1'b1);
        idle(3, 4'hF);
        drive(4'h0, 4'hF, 1'b1, 4'h0, 1'b1);
        idle(3, 4'hF);
        drive(4'h0, 4'hF, 1'b1, 4'h0, 1'b1);
        idle(2, 4'hF);

        // Masked source held pending, delivered after unmask; ack ignored in IDLE
        drive(4'b0001, 4'b1110, 1'b0, 4'h0, 1'b1);
        drive(4'h0, 4'b1110, 1'b1, 4'h0, 1'b1);
        idle(3, 4'b1110);
        idle(3, 4'hF);
        drive(4'h0, 4'hF, 1'b1, 4'h0, 1'b1);
        idle(2, 4'hF);

        // Overrun on source 3, then write-1-to-clear
        drive(4'b1000, 4'hF, 1'b0, 4'h0, 1'b1);
        idle(1, 4'hF);
        drive(4'b1000, 4'hF, 1'b0, 4'h0, 1'b1);
        idle(2, 4'hF);
        drive(4'h0, 4'hF, 1'b0, 4'b1000, 1'b1);
        idle(1, 4'hF);
        drive(4'b1000, 4'hF, 1'b0, 4'b1000, 1'b1);
        idle(1, 4'hF);
        drive(4'h0, 4'hF, 1'b1, 4'b1000, 1'b1);
        idle(2, 4'hF);

        // Ack collides with a new event on the presented source
        drive(4'b0010, 4'hF, 1'b0, 4'h0, 1'b1);
        idle(2, 4'hF);
        drive(4'b0010, 4'hF, 1'b1, 4'h0, 1'b1);
        idle(3, 4'hF);
        drive(4'h0, 4'hF, 1'b1, 4'h0, 1'b1);
        idle(2, 4'hF);

        // Reset aborts an active delivery and discards concurrent events
        drive(4'b0001, 4'hF, 1'b0, 4'h0, 1'b1);
        idle(2, 4'hF);
        drive(4'hF, 4'hF, 1'b0, 4'h0, 1'b0);
        idle(2, 4'hF);

        for (int k = 0; k < 3000; k++) begin
            logic [3:0] r_irq;
            logic [3:0] r_mask;
            logic [3:0] r_clr;
            r_irq  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            r_mask = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
            r_clr  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            drive(r_irq, r_mask, 1'($urandom_range(0, 2) == 0), r_clr,
                  1'($urandom_range(0, 99) != 0));
        end

        idle(2, 4'hF);
        for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(negedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
